// File: rtl/booth_radix4_multiplier_if.sv
// booth_radix4_multiplier_if
//   Request/result bundle between the sequencer and the radix-4 Booth multiplier.
//   Parameter N sets the operand width and must match the multiplier instance.
// Signals
//   start      sequencer -> multiplier  request, taken only while the unit is free
//   is_signed  sequencer -> multiplier  1: two's-complement operands, 0: unsigned
//   m1         sequencer -> multiplier  multiplicand (N bits)
//   m2         sequencer -> multiplier  multiplier (N bits)
//   busy       multiplier -> sequencer  operation in progress
//   done       multiplier -> sequencer  one-cycle pulse, product valid
//   product    multiplier -> sequencer  2N-bit result, held until the next done
// Modports
//   master  sequencer side
//   slave   multiplier side
interface booth_radix4_multiplier_if #(
  parameter int N = 8
);
  logic           start;
  logic           is_signed;
  logic [N-1:0]   m1;
  logic [N-1:0]   m2;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start, is_signed, m1, m2,
    input  busy, done, product
  );

  modport slave (
    input  start, is_signed, m1, m2,
    output busy, done, product
  );
endinterface

// File: rtl/booth_radix4_multiplier.sv
// booth_radix4_multiplier
//   Iterative radix-4 (modified) Booth multiplier retiring two multiplier bits per
//   clock. Supports signed and unsigned operands of generic even width N >= 4.
//   After start is taken, ITER = N/2+1 digit cycles run, followed by one cycle
//   that loads the product register and pulses done.
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous, active-high reset; aborts any operation in flight
//   bus   slave modport of booth_radix4_multiplier_if
//           start/is_signed/m1/m2 in, busy/done/product out
// Configuration
//   BOOTH_R4_EARLY_TERM_EN  when defined, the digit loop stops as soon as all
//                           remaining Booth digits are zero; the result is unchanged.
module booth_radix4_multiplier #(
  parameter int N = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  booth_radix4_multiplier_if.slave    bus
);

  localparam int ITER = N / 2 + 1;
  localparam int AW   = 2 * N + 4;
  localparam int XW   = N + 3;
  localparam int IW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    mcand;
  logic [XW-1:0]    mplier;
  logic [IW-1:0]    idx;
  logic             busy_r;
  logic             done_r;
  logic [2*N-1:0]   product_r;

  logic [AW-1:0]    term;
  logic [AW-1:0]    acc_next;
  logic [XW-1:0]    mplier_next;
  logic             last_digit;
  logic             m1_ext;
  logic             m2_ext;

  // Extension bits for the captured operands: sign bit in signed mode, zero otherwise.
  assign m1_ext = bus.is_signed & bus.m1[N-1];
  assign m2_ext = bus.is_signed & bus.m2[N-1];

  // Booth digit recoding of the low triple of the shifting multiplier register.
  // mcand is already pre-shifted by 4^i, so the partial product needs no weighting
  // here. The multiplier register shifts arithmetically, so once every bit left in
  // it equals the extension bit all later digits are zero.
  always_comb begin
    term = '0;
    case (mplier[2:0])
      3'b001, 3'b010: term = mcand;
      3'b011:         term = mcand << 1;
      3'b100:         term = -(mcand << 1);
      3'b101, 3'b110: term = -mcand;
      default:        term = '0;
    endcase
    acc_next    = acc + term;
    mplier_next = {{2{mplier[XW-1]}}, mplier[XW-1:2]};
    last_digit  = (idx == IW'(ITER - 1));
`ifdef BOOTH_R4_EARLY_TERM_EN
    if ((mplier_next == '0) || (mplier_next == '1)) begin
      last_digit = 1'b1;
    end
`else
`endif
  end

  // Controller and datapath. Index value ITER marks the write-back cycle: the
  // accumulator has settled and is copied into the product register, so the
  // final adder never sits in front of the product/done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      idx       <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          busy_r <= 1'b0;
          if (bus.start) begin
            mcand  <= {{(N + 4){m1_ext}}, bus.m1};
            mplier <= {{2{m2_ext}}, bus.m2, 1'b0};
            acc    <= '0;
            idx    <= '0;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (idx == IW'(ITER)) begin
            product_r <= acc[2*N-1:0];
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
            state     <= DONE;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 2;
            mplier <= mplier_next;
            busy_r <= 1'b1;
            idx    <= last_digit ? IW'(ITER) : idx + IW'(1);
          end
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// tb_booth_radix4_multiplier
//   Directed self-checking bench for booth_radix4_multiplier with N = 8.
//   Each scenario task drives its stimulus and compares against hand-computed
//   results; a short pseudo-random pass compares against an integer model.
module tb_booth_radix4_multiplier;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  booth_radix4_multiplier_if #(.N(8)) bus ();

  booth_radix4_multiplier #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation and follow it to done (bounded). Latency is counted in
  // clock edges after the accepting edge; -1 means done never came.
  task automatic run_op(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busycnt, output int overlap,
                        output logic [15:0] prod);
    lat     = -1;
    busycnt = 0;
    overlap = 0;
    prod    = 'x;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.m1        = a;
    bus.m2        = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (bus.busy === 1'b1) busycnt++;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.busy === 1'b1) busycnt++;
      if (bus.busy === 1'b1 && bus.done === 1'b1) overlap++;
      if (bus.done === 1'b1) begin
        lat  = c;
        prod = bus.product;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.m1        = '0;
    bus.m2        = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_done: got %b expected 0", bus.done);
    end
    checks++;
    if (bus.product !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_product: got %h expected 0000", bus.product);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_signed_corner();
    int lat, bc, ov;
    logic [15:0] p;
    run_op(1'b1, 8'h80, 8'h80, lat, bc, ov, p);
    checks++;
    if (p !== 16'h4000) begin
      failures++;
      $display("[TB] FAIL neg128_sq_product: got %h expected 4000", p);
    end
    checks++;
    if (ov !== 0) begin
      failures++;
      $display("[TB] FAIL busy_done_overlap: got %0d cycles expected 0", ov);
    end
`ifndef BOOTH_R4_EARLY_TERM_EN
    checks++;
    if (lat !== 6) begin
      failures++;
      $display("[TB] FAIL neg128_sq_latency: got %0d expected 6", lat);
    end
    checks++;
    if (bc !== 5) begin
      failures++;
      $display("[TB] FAIL neg128_sq_busy_cycles: got %0d expected 5", bc);
    end
`endif
  endtask

  task automatic test_unsigned_max();
    int lat, bc, ov;
    logic [15:0] p;
    run_op(1'b0, 8'hFF, 8'hFF, lat, bc, ov, p);
    checks++;
    if (p !== 16'hFE01) begin
      failures++;
      $display("[TB] FAIL unsigned_ff_sq: got %h expected fe01", p);
    end
    run_op(1'b1, 8'hFF, 8'hFF, lat, bc, ov, p);
    checks++;
    if (p !== 16'h0001) begin
      failures++;
      $display("[TB] FAIL signed_m1_sq: got %h expected 0001", p);
    end
  endtask

  task automatic test_mixed_vectors();
    logic        sg [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0]  va [4] = '{8'h80, 8'h80, 8'h7F, 8'h00};
    logic [7:0]  vb [4] = '{8'h7F, 8'h7F, 8'h7F, 8'hFF};
    logic [15:0] ve [4] = '{16'hC080, 16'h3F80, 16'h3F01, 16'h0000};
    int lat, bc, ov;
    logic [15:0] p;
    for (int i = 0; i < 4; i++) begin
      run_op(sg[i], va[i], vb[i], lat, bc, ov, p);
      checks++;
      if (p !== ve[i]) begin
        failures++;
        $display("[TB] FAIL vector_%0d: got %h expected %h", i, p, ve[i]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int donecnt = 0;
    int lat     = -1;
    logic [15:0] p = 'x;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = 1'b1;
    bus.m1        = 8'd7;
    bus.m2        = 8'hFD;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.m1        = 8'h55;
    bus.m2        = 8'h22;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.start = (c == 2);
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        donecnt++;
        if (donecnt == 1) begin
          lat = c;
          p   = bus.product;
        end
      end
    end
    bus.start = 1'b0;
    checks++;
    if (p !== 16'hFFEB) begin
      failures++;
      $display("[TB] FAIL busy_ignore_product: got %h expected ffeb", p);
    end
    checks++;
    if (donecnt !== 1) begin
      failures++;
      $display("[TB] FAIL busy_ignore_done_count: got %0d expected 1", donecnt);
    end
`ifndef BOOTH_R4_EARLY_TERM_EN
    checks++;
    if (lat !== 6) begin
      failures++;
      $display("[TB] FAIL busy_ignore_latency: got %0d expected 6", lat);
    end
`endif
  endtask

  task automatic test_reset_abort();
    int donecnt = 0;
    int lat, bc, ov;
    logic [15:0] p;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.m1        = 8'd3;
    bus.m2        = 8'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_busy: got %b expected 0", bus.busy);
    end
    checks++;
    if (bus.product !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL abort_product: got %h expected 0000", bus.product);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) donecnt++;
    end
    checks++;
    if (donecnt !== 0) begin
      failures++;
      $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", donecnt);
    end
    run_op(1'b0, 8'd3, 8'd5, lat, bc, ov, p);
    checks++;
    if (p !== 16'h000F) begin
      failures++;
      $display("[TB] FAIL after_abort_product: got %h expected 000f", p);
    end
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    int lat2 = -1;
    logic [15:0] p1 = 'x;
    logic [15:0] p2 = 'x;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.m1        = 8'd6;
    bus.m2        = 8'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        seen = 1;
        p1   = bus.product;
        break;
      end
    end
    if (seen == 1) begin
      bus.start     = 1'b1;
      bus.is_signed = 1'b0;
      bus.m1        = 8'd10;
      bus.m2        = 8'd12;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk);
        #1;
        if (bus.done === 1'b1) begin
          lat2 = c;
          p2   = bus.product;
          break;
        end
      end
    end
    checks++;
    if (p1 !== 16'h002A) begin
      failures++;
      $display("[TB] FAIL b2b_first_product: got %h expected 002a", p1);
    end
    checks++;
    if (p2 !== 16'h0078) begin
      failures++;
      $display("[TB] FAIL b2b_second_product: got %h expected 0078", p2);
    end
`ifndef BOOTH_R4_EARLY_TERM_EN
    checks++;
    if (lat2 !== 6) begin
      failures++;
      $display("[TB] FAIL b2b_latency: got %0d expected 6", lat2);
    end
`endif
  endtask

`ifdef BOOTH_R4_EARLY_TERM_EN
  task automatic test_early_term();
    int lat, bc, ov;
    logic [15:0] p;
    run_op(1'b1, 8'd100, 8'd3, lat, bc, ov, p);
    checks++;
    if (p !== 16'h012C || lat !== 3) begin
      failures++;
      $display("[TB] FAIL early_100x3: got %h lat %0d expected 012c lat 3", p, lat);
    end
    run_op(1'b1, 8'd100, 8'd0, lat, bc, ov, p);
    checks++;
    if (p !== 16'h0000 || lat !== 2) begin
      failures++;
      $display("[TB] FAIL early_100x0: got %h lat %0d expected 0000 lat 2", p, lat);
    end
  endtask
`endif

  task automatic test_random();
    int lat, bc, ov;
    logic [15:0] p;
    logic [15:0] exp_p;
    logic [7:0]  a, b;
    logic        sgn;
    logic signed [15:0] sa, sb;
    for (int i = 0; i < 60; i++) begin
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      sgn = 1'($urandom_range(0, 1));
      sa  = {{8{a[7]}}, a};
      sb  = {{8{b[7]}}, b};
      exp_p = sgn ? 16'(sa * sb) : 16'({8'h00, a} * {8'h00, b});
      run_op(sgn, a, b, lat, bc, ov, p);
      checks++;
      if (p !== exp_p) begin
        failures++;
        $display("[TB] FAIL random_%0d (%0d %h*%h): got %h expected %h", i, sgn, a, b, p, exp_p);
      end
    end
  endtask

  initial begin
    $display("[TB] booth_radix4_multiplier bench starting");
    test_reset();
    test_signed_corner();
    test_unsigned_max();
    test_mixed_vectors();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
`ifdef BOOTH_R4_EARLY_TERM_EN
    test_early_term();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
